irq_controller: RTL and testbench

- Priority interrupt controller that sequences the core's interrupt handshake.
- Collects edge-triggered requests from up to 15 peripheral sources (keyboard, UART, timer, ...).
- Presents the highest-priority enabled request on the core's 4-bit interrupt_vector and holds it until interrupt_ack.
- Blocks further requests until the handler signals completion at mret. No nesting.

---
 rtl/irq_controller.sv | 172 +++++++++++++++++
 tb/tb_irq_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Priority interrupt controller: edge-triggered request capture, lowest-index
// priority selection and a non-nesting present/ack/complete handshake with the core.
module irq_controller #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [3:0]         interrupt_vector,
    input  logic               interrupt_ack,
    input  logic               irq_complete,
    input  logic [1:0]         cfg_addr,
    input  logic               cfg_we,
    input  logic [15:0]        cfg_wdata,
    input  logic               cfg_re,
    output logic [15:0]        cfg_rdata
);

    // Encodings are architecturally visible through the status register.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE   = 2'd0;
    localparam logic [1:0] ADDR_PENDING  = 2'd1;
    localparam logic [1:0] ADDR_OVERFLOW = 2'd2;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cur_id;
    logic [3:0]         w_cur_id_next;
    logic [3:0]         r_vector;
    logic [3:0]         w_vector_next;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_overflow;
    logic [NUM_SRC-1:0] r_irq_src_q;
    logic [15:0]        r_rdata;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_ready;
    logic [NUM_SRC-1:0] w_ack_mask;
    logic [NUM_SRC-1:0] w_pend_clr;
    logic [NUM_SRC-1:0] w_ovf_clr;
    logic [3:0]         w_winner;
    logic [15:0]        w_rd_mux;
    logic               w_ack_taken;
    logic               w_unused_wdata;

    // Only the low NUM_SRC bits of the write data are meaningful.
    assign w_unused_wdata = ^cfg_wdata;

    assign w_edge      = irq_src & ~r_irq_src_q;
    assign w_ready     = r_pending & r_enable;
    assign w_ack_taken = (r_state == ST_PRESENT) && interrupt_ack;
    assign w_pend_clr  = (cfg_we && cfg_addr == ADDR_PENDING)  ? cfg_wdata[NUM_SRC-1:0] : '0;
    assign w_ovf_clr   = (cfg_we && cfg_addr == ADDR_OVERFLOW) ? cfg_wdata[NUM_SRC-1:0] : '0;

    // Priority encoder: scanning downward lets the lowest ready index win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_winner = 4'(i);
            end
        end
    end

    // One-hot mask of the source whose pending bit the ack retires.
    always_comb begin
        w_ack_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_mask[i] = w_ack_taken && (r_cur_id == 4'(i));
        end
    end

    // Handshake next-state, presented vector and captured source id.
    always_comb begin
        w_state_next  = r_state;
        w_cur_id_next = r_cur_id;
        w_vector_next = r_vector;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ready != '0) begin
                    w_cur_id_next = w_winner;
                    w_vector_next = 4'(w_winner + 4'd1);
                    w_state_next  = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Vector is held regardless of later enable/pending changes.
                if (interrupt_ack) begin
                    w_vector_next = '0;
                    w_state_next  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (irq_complete) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_vector_next = '0;
                w_state_next  = ST_IDLE;
            end
        endcase
    end

    // FSM state register together with the registered vector and source id.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cur_id <= '0;
            r_vector <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cur_id <= w_cur_id_next;
            r_vector <= w_vector_next;
        end
    end

    // Request capture: a new edge always lands in pending, beating W1C and ack clears;
    // an edge on an already-pending bit is lost and flagged, except when the ack retires it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_src_q <= '0;
            r_pending   <= '0;
            r_overflow  <= '0;
        end else begin
            r_irq_src_q <= irq_src;
            r_pending   <= (r_pending & ~w_pend_clr & ~w_ack_mask) | w_edge;
            r_overflow  <= (r_overflow & ~w_ovf_clr) | (w_edge & r_pending & ~w_ack_mask);
        end
    end

    // Enable register write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable <= '0;
        end else if (cfg_we && cfg_addr == ADDR_ENABLE) begin
            r_enable <= cfg_wdata[NUM_SRC-1:0];
        end
    end

    // Read mux built from current register values, so a same-cycle write is not visible.
    always_comb begin
        w_rd_mux = '0;
        unique case (cfg_addr)
            ADDR_ENABLE:   w_rd_mux[NUM_SRC-1:0] = r_enable;
            ADDR_PENDING:  w_rd_mux[NUM_SRC-1:0] = r_pending;
            ADDR_OVERFLOW: w_rd_mux[NUM_SRC-1:0] = r_overflow;
            default:       w_rd_mux = {10'b0, r_state, r_cur_id};
        endcase
    end

    // Read data register: updated only by a read strobe, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (cfg_re) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign interrupt_vector = r_vector;
    assign cfg_rdata        = r_rdata;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a driver applies directed and random
// stimulus while a cycle-level reference model queues expected vector changes
// and read data; an independent monitor compares whatever the DUT presents.
module tb_irq_controller;

    localparam int N = 4;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } vec_ev_t;

    logic          clk;
    logic          reset;
    logic [N-1:0]  irq_src;
    logic [3:0]    interrupt_vector;
    logic          interrupt_ack;
    logic          irq_complete;
    logic [1:0]    cfg_addr;
    logic          cfg_we;
    logic [15:0]   cfg_wdata;
    logic          cfg_re;
    logic [15:0]   cfg_rdata;

    irq_controller #(.NUM_SRC(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .irq_src          (irq_src),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .irq_complete     (irq_complete),
        .cfg_addr         (cfg_addr),
        .cfg_we           (cfg_we),
        .cfg_wdata        (cfg_wdata),
        .cfg_re           (cfg_re),
        .cfg_rdata        (cfg_rdata)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    vec_ev_t      vec_q[$];
    logic [15:0]  rd_q[$];

    // Stimulus values applied on the next tick.
    logic         t_rst, t_ack, t_cmp, t_we, t_re;
    logic [N-1:0] t_src;
    logic [1:0]   t_addr;
    logic [15:0]  t_wd;

    // Reference model state, described in terms of the handshake phases.
    logic [N-1:0] m_en, m_pend, m_ovf, m_src_prev;
    logic         m_presenting, m_servicing;
    logic [3:0]   m_cur, m_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Record a change of the expected vector, visible after the coming clock edge.
    task automatic set_vec(input logic [3:0] v);
        vec_ev_t ev;
        if (v != m_vec) begin
            ev.cyc = cyc + 1;
            ev.vec = v;
            vec_q.push_back(ev);
        end
        m_vec = v;
    endtask

    // Apply one cycle of stimulus and advance the model across the coming edge.
    task automatic tick();
        logic [N-1:0] edges, ack_bit, pclr, oclr, ready;
        logic [1:0]   st;
        @(negedge clk);
        reset         = t_rst;
        irq_src       = t_src;
        interrupt_ack = t_ack;
        irq_complete  = t_cmp;
        cfg_addr      = t_addr;
        cfg_we        = t_we;
        cfg_wdata     = t_wd;
        cfg_re        = t_re;
        if (t_rst) begin
            m_en = '0; m_pend = '0; m_ovf = '0; m_src_prev = '0;
            m_presenting = 1'b0; m_servicing = 1'b0; m_cur = '0;
            set_vec(4'd0);
        end else begin
            if (t_re) begin
                st = m_presenting ? 2'd1 : (m_servicing ? 2'd2 : 2'd0);
                case (t_addr)
                    2'd0:    rd_q.push_back(16'(m_en));
                    2'd1:    rd_q.push_back(16'(m_pend));
                    2'd2:    rd_q.push_back(16'(m_ovf));
                    default: rd_q.push_back({10'b0, st, m_cur});
                endcase
            end
            edges   = t_src & ~m_src_prev;
            ack_bit = (m_presenting && t_ack) ? N'(1 << m_cur) : '0;
            pclr    = (t_we && t_addr == 2'd1) ? t_wd[N-1:0] : '0;
            oclr    = (t_we && t_addr == 2'd2) ? t_wd[N-1:0] : '0;
            ready   = m_pend & m_en;
            m_ovf   = (m_ovf & ~oclr) | (edges & m_pend & ~ack_bit);
            m_pend  = (m_pend & ~pclr & ~ack_bit) | edges;
            if (t_we && t_addr == 2'd0) m_en = t_wd[N-1:0];
            m_src_prev = t_src;
            if (m_presenting) begin
                if (t_ack) begin
                    m_presenting = 1'b0;
                    m_servicing  = 1'b1;
                    set_vec(4'd0);
                end
            end else if (m_servicing) begin
                if (t_cmp) m_servicing = 1'b0;
            end else if (ready != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (ready[i]) begin
                        m_cur = 4'(i);
                        break;
                    end
                end
                m_presenting = 1'b1;
                set_vec(m_cur + 4'd1);
            end
        end
        t_rst = 1'b0; t_ack = 1'b0; t_cmp = 1'b0; t_we = 1'b0; t_re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        t_we = 1'b1; t_addr = a; t_wd = d;
        tick();
    endtask

    task automatic rd(input logic [1:0] a);
        t_re = 1'b1; t_addr = a;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        t_rst = 1'b1; tick();
        t_rst = 1'b1; tick();
    endtask

    // Cycle counter shared by model timestamps and monitor.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a read is presented the cycle after the DUT accepts cfg_re.
    logic       rd_seen = 1'b0;
    logic [3:0] mon_prev = 4'd0;
    always @(posedge clk) rd_seen <= cfg_re && !reset;

    always @(negedge clk) begin
        vec_ev_t ev;
        if (cyc >= 2) begin
            if (interrupt_vector !== mon_prev) begin
                if (vec_q.size() == 0) begin
                    check("vec_unexpected", 32'(interrupt_vector), 32'(mon_prev));
                end else begin
                    ev = vec_q.pop_front();
                    check("vec_value", 32'(interrupt_vector), 32'(ev.vec));
                    check("vec_cycle", cyc, ev.cyc);
                end
                mon_prev = interrupt_vector;
            end
            if (rd_seen) begin
                if (rd_q.size() == 0) check("rd_expected", rd_q.size(), 1);
                else check("cfg_rdata", 32'(cfg_rdata), 32'(rd_q.pop_front()));
            end
        end
    end

    initial begin
        t_rst = 1'b0; t_ack = 1'b0; t_cmp = 1'b0; t_we = 1'b0; t_re = 1'b0;
        t_src = '0; t_addr = '0; t_wd = '0;
        reset = 1'b1; irq_src = '0; interrupt_ack = 1'b0; irq_complete = 1'b0;
        cfg_addr = '0; cfg_we = 1'b0; cfg_wdata = '0; cfg_re = 1'b0;
        m_en = '0; m_pend = '0; m_ovf = '0; m_src_prev = '0;
        m_presenting = 1'b0; m_servicing = 1'b0; m_cur = '0; m_vec = '0;

        // Reset state of every register.
        do_reset();
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);

        // Single request through the full handshake.
        wr(2'd0, 16'h0001);
        t_src = 4'b0001; idle(4);
        t_ack = 1'b1; tick();
        rd(2'd3); idle(2);
        t_cmp = 1'b1; tick();
        rd(2'd3);
        t_src = '0; idle(2);

        // Priority between simultaneous requests.
        wr(2'd0, 16'h000F);
        t_src = 4'b1010; idle(3);
        t_ack = 1'b1; tick(); idle(1);
        t_cmp = 1'b1; tick(); idle(2);
        t_ack = 1'b1; tick();
        t_cmp = 1'b1; tick();
        rd(2'd1);
        t_src = '0; idle(2);

        // Masked request, later enabled; then W1C colliding with a new edge.
        wr(2'd0, 16'h0000);
        t_src = 4'b0100; tick();
        rd(2'd1);
        wr(2'd0, 16'h0004); idle(2);
        t_ack = 1'b1; tick();
        t_cmp = 1'b1; tick();
        t_src = '0; wr(2'd0, 16'h0000);
        t_src = 4'b0100; tick();
        t_src = '0; tick();
        t_src = 4'b0100; wr(2'd1, 16'h0004);
        rd(2'd1); rd(2'd2);
        t_src = '0;

        // Overflow on a repeated request, then clear it.
        do_reset();
        t_src = 4'b0010; tick();
        t_src = 4'b0000; tick();
        t_src = 4'b0010; tick();
        rd(2'd1); rd(2'd2);
        wr(2'd2, 16'h0002);
        rd(2'd2);
        t_src = '0;

        // Re-trigger of the serviced source in the ack cycle.
        do_reset();
        wr(2'd0, 16'h0001);
        t_src = 4'b0001; tick();
        t_src = 4'b0000; idle(2);
        t_src = 4'b0001; t_ack = 1'b1; tick();
        rd(2'd1); rd(2'd2);
        t_cmp = 1'b1; tick(); idle(3);
        t_ack = 1'b1; tick();
        t_cmp = 1'b1; tick();
        t_src = '0;

        // Reset while presenting, then a stale completion.
        do_reset();
        wr(2'd0, 16'h0002);
        t_src = 4'b0010; idle(3);
        t_rst = 1'b1; tick();
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
        t_cmp = 1'b1; tick();
        rd(2'd3);
        t_src = '0; idle(2);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) == 0) t_src = t_src ^ N'(1 << $urandom_range(0, N - 1));
            t_ack  = ($urandom_range(0, 3) == 0);
            t_cmp  = ($urandom_range(0, 3) == 0);
            t_re   = ($urandom_range(0, 2) == 0);
            t_we   = ($urandom_range(0, 7) == 0);
            t_addr = 2'($urandom_range(0, 3));
            t_wd   = 16'($urandom);
            t_rst  = ($urandom_range(0, 299) == 0);
            tick();
        end

        // Drain and confirm nothing expected was left unobserved.
        t_src = '0; idle(4);
        @(negedge clk); #1;
        check("vec_queue_drained", vec_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
